// File: rtl/antisat_key_loader_if.sv
// antisat_key_loader_if: provisioning handshake plus key bus between provisioning master and key loader.
// Latency: none, wires only.
// Backpressure: key_ready from the loader qualifies key_valid/key_bit from the master.
interface antisat_key_loader_if #(
  parameter int KEY_W = 40
);
  logic             load_start;
  logic             key_bit;
  logic             key_valid;
  logic             key_ready;
  logic [KEY_W-1:0] key_out;
  logic             key_armed;
  logic             load_err;
  logic             locked_out;
  logic             busy;

  modport master (
    output load_start, key_bit, key_valid,
    input  key_ready, key_out, key_armed, load_err, locked_out, busy
  );

  modport slave (
    input  load_start, key_bit, key_valid,
    output key_ready, key_out, key_armed, load_err, locked_out, busy
  );
endinterface

// File: rtl/antisat_key_loader.sv
// antisat_key_loader: serial LSB-first Anti-SAT key load into a shadow register, committed whole to key_out.
// Latency: key_out/key_armed valid the cycle after the last accepted beat (KEY_W+1 cycles min from load_start).
// Backpressure: key_ready high only while loading; key_valid low stalls. Optional parity beat: ANTISAT_KEY_PARITY_CHECK_EN.
module antisat_key_loader #(
  parameter int KEY_W    = 40,
  parameter int MAX_FAIL = 3
) (
  input logic                 clk,
  input logic                 rst,
  antisat_key_loader_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
`ifdef ANTISAT_KEY_PARITY_CHECK_EN
    S_PAR     = 3'd2,
`endif
    S_ARMED   = 3'd3,
    S_LOCKOUT = 3'd4
  } state_t;

  state_t           r_state;
  logic [KEY_W-1:0] r_shadow;
  logic [5:0]       r_cnt;
  logic             r_par;
  logic [KEY_W-1:0] r_key_out;
  logic             r_key_armed;
`ifdef ANTISAT_KEY_PARITY_CHECK_EN
  logic [3:0]       r_fail_cnt;
  logic             r_load_err;
  logic             r_locked_out;
`endif

  logic             w_ready;
  logic             w_beat;
  logic             w_restart;
  logic             w_last;
  logic [KEY_W-1:0] w_shadow_nxt;

  // Ready/busy decode straight from the registered state
  always_comb begin
    w_ready = (r_state == S_LOAD);
`ifdef ANTISAT_KEY_PARITY_CHECK_EN
    if (r_state == S_PAR) w_ready = 1'b1;
`endif
  end

  assign w_beat       = bus.key_valid & w_ready;
  // load_start wins over any simultaneous beat; only lockout ignores it
  assign w_restart    = bus.load_start && (r_state != S_LOCKOUT);
  assign w_last       = (r_cnt == 6'(KEY_W - 1));
  // shadow is cleared at load start, so OR-ing the new bit in at cnt is a write
  assign w_shadow_nxt = r_shadow | (KEY_W'(bus.key_bit) << r_cnt);

  // Load/commit/lockout state machine with registered key and status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_shadow     <= '0;
      r_cnt        <= '0;
      r_par        <= 1'b0;
      r_key_out    <= '0;
      r_key_armed  <= 1'b0;
`ifdef ANTISAT_KEY_PARITY_CHECK_EN
      r_fail_cnt   <= '0;
      r_load_err   <= 1'b0;
      r_locked_out <= 1'b0;
`endif
    end else begin
`ifdef ANTISAT_KEY_PARITY_CHECK_EN
      r_load_err <= 1'b0;
`endif
      if (w_restart) begin
        // Downstream netlist drops back to the all-zero key for the whole load
        r_state     <= S_LOAD;
        r_cnt       <= '0;
        r_par       <= 1'b0;
        r_shadow    <= '0;
        r_key_out   <= '0;
        r_key_armed <= 1'b0;
      end else begin
        case (r_state)
          S_LOAD: begin
            if (w_beat) begin
              r_shadow <= w_shadow_nxt;
              r_par    <= r_par ^ bus.key_bit;
              r_cnt    <= w_last ? 6'd0 : r_cnt + 6'd1;
              if (w_last) begin
`ifdef ANTISAT_KEY_PARITY_CHECK_EN
                r_state <= S_PAR;
`else
                r_key_out   <= w_shadow_nxt;
                r_key_armed <= 1'b1;
                r_state     <= S_ARMED;
`endif
              end
            end
          end
`ifdef ANTISAT_KEY_PARITY_CHECK_EN
          S_PAR: begin
            if (w_beat) begin
              if ((r_par ^ bus.key_bit) == 1'b0) begin
                r_key_out   <= r_shadow;
                r_key_armed <= 1'b1;
                r_fail_cnt  <= '0;
                r_state     <= S_ARMED;
              end else begin
                // Bad parity: discard the key, count the failure
                r_shadow   <= '0;
                r_fail_cnt <= r_fail_cnt + 4'd1;
                r_load_err <= 1'b1;
                if ((r_fail_cnt + 4'd1) == 4'(MAX_FAIL)) begin
                  r_state      <= S_LOCKOUT;
                  r_locked_out <= 1'b1;
                end else begin
                  r_state <= S_IDLE;
                end
              end
            end
          end
          S_LOCKOUT: begin
            r_load_err   <= 1'b1;
            r_locked_out <= 1'b1;
            r_key_out    <= '0;
          end
`endif
          default: ;
        endcase
      end
    end
  end

  assign bus.key_ready  = w_ready;
  assign bus.busy       = w_ready;
  assign bus.key_out    = r_key_out;
  assign bus.key_armed  = r_key_armed;
`ifdef ANTISAT_KEY_PARITY_CHECK_EN
  assign bus.load_err   = r_load_err;
  assign bus.locked_out = r_locked_out;
`else
  assign bus.load_err   = 1'b0;
  assign bus.locked_out = 1'b0;
`endif

endmodule

// File: doc/antisat_key_loader.md
# antisat_key_loader

- Loads the 40-bit Anti-SAT key serially from the secure provisioning port.
- Holds the key in a shadow register and drives it, fully formed, onto the `keyIn_0_*` bus of the locked combinational netlist that sits directly downstream.
- The downstream netlist sees an all-zero key until a complete load has been accepted, so a partial key never reaches the logic.
- Repeated failed loads lock the port out until reset.

## Interface
- `KEY_W`, 40, key width. Bit i drives `keyIn_0_i`.
- `MAX_FAIL`, 3, failed loads that trigger lockout. Range 1..15.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `load_start`  in  1  one-cycle request that begins a new load.
- `key_bit`  in  1  serial key data.
- `key_valid`  in  1  `key_bit` is valid this cycle.
- `key_ready`  out  1  loader accepts a bit this cycle.
- `key_out`  out  KEY_W  key bus to the locked netlist.
- `key_armed`  out  1  `key_out` holds a complete, accepted key.
- `load_err`  out  1  load failure indication.
- `locked_out`  out  1  fail limit reached.
- `busy`  out  1  a load is in progress.

## Operation
- States: IDLE, LOAD, PAR (only with the macro), ARMED, LOCKOUT.
- Registers: `shadow[KEY_W-1:0]`, bit counter `cnt` (6 bits, 0..KEY_W-1), `fail_cnt` (4 bits), running parity `par`.
- **Reset:**
  - State goes to IDLE.
  - `shadow`, `key_out`, `cnt`, `fail_cnt` and `par` go to 0.
  - All outputs go to 0.
- **IDLE / ARMED, `load_start`=1:**
  - Next state is LOAD.
  - `cnt`, `par` and `shadow` are cleared.
  - `key_out` is forced to 0 and `key_armed` deasserts.
- **LOAD:**
  - `key_ready`=1 and `busy`=1.
  - Each beat is accepted on `key_valid & key_ready`.
  - An accepted beat writes `shadow[cnt] <= key_bit`, so the key is loaded LSB first.
  - An accepted beat also updates `par ^= key_bit` and `cnt++`.
  - Cycles with `key_valid`=0 are stall cycles and change nothing.
- **Last beat (`cnt`==KEY_W-1 accepted):**
  - With the macro, next state is PAR.
  - Without the macro, the loader commits:
    - `key_out <= shadow` with the final bit included.
    - `key_armed <= 1`.
    - `fail_cnt <= 0`.
    - Next state is ARMED.
- **`load_start` during LOAD or PAR:** restarts the load (same clears as above). It has priority over a simultaneous beat, and that beat is dropped.
- **ARMED:**
  - `key_out` and `key_armed` hold until reset or `load_start`.
  - Inputs other than `load_start` are ignored.
- **LOCKOUT:**
  - `key_ready`=0, `key_out`=0, `load_err`=1, `locked_out`=1.
  - `load_start` is ignored.
  - Only `rst` exits.
- `load_err` outside LOCKOUT is a single-cycle pulse.

## Timing
- All outputs are registered, except `key_ready` and `busy`, which decode the registered state.
- `load_start` at edge N:
  - `busy` and `key_ready` are high from cycle N+1.
  - `key_out` is 0 from cycle N+1.
- Final accepted beat (no macro) or parity beat (macro) at edge M: `key_out` and `key_armed` are valid from cycle M+1.
- Minimum load, with no stalls:
  - 1 + KEY_W cycles from the `load_start` edge to armed.
  - One extra cycle with the macro.
- Back-to-back `load_start` pulses each restart the load. A load is never resumed.
- Reset asserted mid-load:
  - Clears immediately and asynchronously.
  - No partial key ever appears on `key_out`.

## Configuration
- Macro: `ANTISAT_KEY_PARITY_CHECK_EN`.
- **Defined:**
  - After KEY_W key bits, PAR accepts one extra beat carrying the even-parity bit.
  - Match (`par ^ key_bit`==0): commit as above.
  - Mismatch:
    - `load_err` pulses for one cycle.
    - `fail_cnt++` and `shadow` is cleared.
    - `key_out` stays 0 and next state is IDLE.
    - If `fail_cnt` reaches MAX_FAIL, next state is LOCKOUT instead.
- **Undefined:**
  - No PAR state.
  - `load_err` and `locked_out` are tied to 0.
  - `fail_cnt` is removed.

## Test plan
- Reset then idle 10 cycles -> `key_out`=0, `key_armed`=0, `key_ready`=0, `busy`=0.
- `load_start`, then 40 beats of 40'hF0F0F0F0F0 LSB first with no stalls:
  - `key_armed` rises 41 cycles after `load_start`, and `key_out`=40'hF0F0F0F0F0.
  - With the macro, a parity bit of 0 is sent after the 40 beats; `key_armed` rises one cycle later (42 cycles) with the same `key_out`.
- The same load with `key_valid` deasserted on every other cycle -> identical `key_out`; `key_armed` rises at 81 cycles.
- Key 40'h123456789A, with `load_start` reasserted at beat 17, then a full reload of 40'h00000FFFFF:
  - `key_out` is never nonzero before arm.
  - Final `key_out`=40'h00000FFFFF.
- Macro defined, `MAX_FAIL`=3, three loads of 40'h0000000001 with parity bit 0:
  - Three single-cycle `load_err` pulses.
  - After the third, `locked_out`=1 and `load_err`=1, with `key_ready`=0.
  - A following `load_start` is ignored.
  - `rst` recovers.
- Armed with 40'hFFFFFFFFFF, then `rst` pulsed asynchronously mid-cycle -> `key_out`=0 and `key_armed`=0 before the next clock edge.
